// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types and constants for the register file write scheduler.
// Pure declarations, no logic or latency of its own.
// No flow control here; the grant logic lives in the top level.
package regfileSchedPkg;

  localparam int RF_NUM_REGS     = 32;
  localparam int RF_ADDR_W       = 5;
  localparam int RF_DATA_W       = 32;
  localparam int NUM_WRITE_PORTS = 2;

  // One register file write port request.
  typedef struct packed {
    logic                 we;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } writeReq;

  // Round-robin owner between the two out-of-band writers.
  typedef enum logic {
    RR_LSU = 1'b0,
    RR_MDU = 1'b1
  } rrOwner;

  // One-hot decode of a register address into a scoreboard mask.
  function automatic logic [RF_NUM_REGS-1:0] regOnehot(input logic [RF_ADDR_W-1:0] addr);
    logic [RF_NUM_REGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Bundle of all decode/issue, writer and register file signals of the scheduler.
// Wiring only, zero latency.
// lsuReady/mduReady are the only backpressure signals; the core path has none.
interface regfile_write_scheduler_if
  import regfileSchedPkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W
);
  logic              exceptionPending;
  logic              coreWeA;
  logic              coreWeB;
  logic [ADDR_W-1:0] coreAddrA;
  logic [ADDR_W-1:0] coreAddrB;
  logic [DATA_W-1:0] coreDataA;
  logic [DATA_W-1:0] coreDataB;
  logic              issueLsu;
  logic [ADDR_W-1:0] issueLsuAddr;
  logic              issueMdu;
  logic              issueMduHiEn;
  logic [ADDR_W-1:0] issueMduLo;
  logic [ADDR_W-1:0] issueMduHi;
  logic              lsuValid;
  logic [ADDR_W-1:0] lsuAddr;
  logic [DATA_W-1:0] lsuData;
  logic              lsuReady;
  logic              mduValid;
  logic              mduHiEn;
  logic [ADDR_W-1:0] mduAddrLo;
  logic [ADDR_W-1:0] mduAddrHi;
  logic [DATA_W-1:0] mduDataLo;
  logic [DATA_W-1:0] mduDataHi;
  logic              mduReady;
  logic              readEnA;
  logic              readEnB;
  logic [ADDR_W-1:0] readAddrA;
  logic [ADDR_W-1:0] readAddrB;
  logic              destEn;
  logic [ADDR_W-1:0] destAddr;
  logic              stall;
  logic              rfWeA;
  logic              rfWeB;
  logic [ADDR_W-1:0] rfAddrA;
  logic [ADDR_W-1:0] rfAddrB;
  logic [DATA_W-1:0] rfDataA;
  logic [DATA_W-1:0] rfDataB;
  logic [NUM_REGS-1:0] busyMask;

  modport master (
    output exceptionPending, coreWeA, coreWeB, coreAddrA, coreAddrB, coreDataA, coreDataB,
    output issueLsu, issueLsuAddr, issueMdu, issueMduHiEn, issueMduLo, issueMduHi,
    output lsuValid, lsuAddr, lsuData, mduValid, mduHiEn, mduAddrLo, mduAddrHi, mduDataLo, mduDataHi,
    output readEnA, readEnB, readAddrA, readAddrB, destEn, destAddr,
    input  lsuReady, mduReady, stall, rfWeA, rfWeB, rfAddrA, rfAddrB, rfDataA, rfDataB, busyMask
  );

  modport slave (
    input  exceptionPending, coreWeA, coreWeB, coreAddrA, coreAddrB, coreDataA, coreDataB,
    input  issueLsu, issueLsuAddr, issueMdu, issueMduHiEn, issueMduLo, issueMduHi,
    input  lsuValid, lsuAddr, lsuData, mduValid, mduHiEn, mduAddrLo, mduAddrHi, mduDataLo, mduDataHi,
    input  readEnA, readEnB, readAddrA, readAddrB, destEn, destAddr,
    output lsuReady, mduReady, stall, rfWeA, rfWeB, rfAddrA, rfAddrB, rfDataA, rfDataB, busyMask
  );
endinterface

// File: rtl/regfile_write_scheduler_scoreboard.sv
// Busy scoreboard for registers with an outstanding LSU/MDU write, plus hazard lookup.
// Masks take effect on the next edge; stall is combinational from registered state (no bypass).
// No handshake; set/clear masks are applied unconditionally every edge.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REGS-1:0] clr_mask,
  input  logic [NUM_REGS-1:0] set_mask,
  input  logic                rd_en_a,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic                rd_en_b,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  input  logic                dest_en,
  input  logic [ADDR_W-1:0]   dest_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                stall
);

  logic [NUM_REGS-1:0] busy_q;

  // Clear completed writes first, then set new issues so a same-cycle issue keeps the bit busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

  // Three-way hazard lookup against the registered busy bits only.
  always_comb begin
    stall = (rd_en_a && busy_q[rd_addr_a]) ||
            (rd_en_b && busy_q[rd_addr_b]) ||
            (dest_en && busy_q[dest_addr]);
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_write_scheduler.sv
// Allocates the two register file write ports between core writeback, LSU and MDU.
// Zero-latency combinational grant; granted writes land on the same edge.
// Core is never backpressured; LSU/MDU hold their request until ready, RR on contention.
module regfile_write_scheduler
  import regfileSchedPkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  regfile_write_scheduler_if.slave  bus
);

  logic                       core_a;
  logic                       core_b;
  logic [NUM_WRITE_PORTS-1:0] port_free;
  logic [1:0]                 free_cnt;
  logic                       lsu_fit;
  logic                       mdu_fit;
  logic                       both_fit;
  logic                       contend;
  logic                       lsu_gnt;
  logic                       mdu_gnt;
  logic                       lsu_ok;
  logic                       mdu_ok;
  logic                       rr_advance;
  rrOwner                     rr_q;
  writeReq                    port_a;
  writeReq                    port_b;
  logic [NUM_REGS-1:0]        clr_mask;
  logic [NUM_REGS-1:0]        set_mask;

  // Port accounting and grant decision: core first, then LSU/MDU by fit and round-robin.
  always_comb begin
    core_a    = bus.coreWeA && !bus.exceptionPending;
    core_b    = bus.coreWeB && !bus.exceptionPending;
    port_free = {!core_b, !core_a};
    free_cnt  = 2'($countones(port_free));
    lsu_fit   = bus.lsuValid && (free_cnt >= 2'd1);
    mdu_fit   = bus.mduValid && (free_cnt >= (bus.mduHiEn ? 2'd2 : 2'd1));
    // Only one combination satisfies both: two free ports and a single-write MDU.
    both_fit  = bus.lsuValid && bus.mduValid && (free_cnt == 2'd2) && !bus.mduHiEn;
    contend   = bus.lsuValid && bus.mduValid && !both_fit;
    lsu_gnt   = 1'b0;
    mdu_gnt   = 1'b0;
    if (both_fit) begin
      lsu_gnt = 1'b1;
      mdu_gnt = 1'b1;
    end else if (contend) begin
      // Favoured requester wins if it fits; otherwise the other one may still use the free port.
      if (rr_q == RR_LSU) begin
        lsu_gnt = lsu_fit;
        mdu_gnt = !lsu_fit && mdu_fit;
      end else begin
        mdu_gnt = mdu_fit;
        lsu_gnt = !mdu_fit && lsu_fit;
      end
    end else begin
      lsu_gnt = lsu_fit;
      mdu_gnt = mdu_fit;
    end
    lsu_ok     = reset && lsu_gnt;
    mdu_ok     = reset && mdu_gnt;
    rr_advance = contend && (((rr_q == RR_LSU) && lsu_gnt) || ((rr_q == RR_MDU) && mdu_gnt));
  end

  // Steer granted writes onto ports: LSU takes A if free, MDU pair is Lo->A/Hi->B.
  always_comb begin
    port_a.we   = core_a;
    port_a.addr = bus.coreAddrA;
    port_a.data = bus.coreDataA;
    port_b.we   = core_b;
    port_b.addr = bus.coreAddrB;
    port_b.data = bus.coreDataB;
    if (lsu_gnt) begin
      if (!core_a) begin
        port_a.we   = 1'b1;
        port_a.addr = bus.lsuAddr;
        port_a.data = bus.lsuData;
      end else begin
        port_b.we   = 1'b1;
        port_b.addr = bus.lsuAddr;
        port_b.data = bus.lsuData;
      end
    end
    if (mdu_gnt) begin
      if (bus.mduHiEn) begin
        port_a.we   = 1'b1;
        port_a.addr = bus.mduAddrLo;
        port_a.data = bus.mduDataLo;
        port_b.we   = 1'b1;
        port_b.addr = bus.mduAddrHi;
        port_b.data = bus.mduDataHi;
      end else if (core_a || lsu_gnt) begin
        port_b.we   = 1'b1;
        port_b.addr = bus.mduAddrLo;
        port_b.data = bus.mduDataLo;
      end else begin
        port_a.we   = 1'b1;
        port_a.addr = bus.mduAddrLo;
        port_a.data = bus.mduDataLo;
      end
    end
  end

  // Scoreboard updates: completed LSU/MDU writes clear, new issues set; core writes never touch it.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (lsu_ok)                 clr_mask = clr_mask | regOnehot(bus.lsuAddr);
    if (mdu_ok)                 clr_mask = clr_mask | regOnehot(bus.mduAddrLo);
    if (mdu_ok && bus.mduHiEn)  clr_mask = clr_mask | regOnehot(bus.mduAddrHi);
    if (bus.issueLsu)           set_mask = set_mask | regOnehot(bus.issueLsuAddr);
    if (bus.issueMdu)           set_mask = set_mask | regOnehot(bus.issueMduLo);
    if (bus.issueMdu && bus.issueMduHiEn) set_mask = set_mask | regOnehot(bus.issueMduHi);
  end

  // Round-robin pointer flips only after the favoured side won an actual contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          rr_q <= RR_LSU;
    else if (rr_advance) rr_q <= (rr_q == RR_LSU) ? RR_MDU : RR_LSU;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .clr_mask  (clr_mask),
    .set_mask  (set_mask),
    .rd_en_a   (bus.readEnA),
    .rd_addr_a (bus.readAddrA),
    .rd_en_b   (bus.readEnB),
    .rd_addr_b (bus.readAddrB),
    .dest_en   (bus.destEn),
    .dest_addr (bus.destAddr),
    .busy      (bus.busyMask),
    .stall     (bus.stall)
  );

  // Output drive; write enables and readies are held low while reset is asserted.
  always_comb begin
    bus.rfWeA    = reset && port_a.we;
    bus.rfAddrA  = port_a.addr;
    bus.rfDataA  = port_a.data;
    bus.rfWeB    = reset && port_b.we;
    bus.rfAddrB  = port_b.addr;
    bus.rfDataB  = port_b.data;
    bus.lsuReady = lsu_ok;
    bus.mduReady = mdu_ok;
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for the write scheduler with a per-cycle expected-result queue.
// Expectations are pushed as each cycle's stimulus is driven and popped at the falling edge.
// Direct checks cover scoreboard contents and asynchronous reset behaviour.
module tb_regfile_write_scheduler;
  import regfileSchedPkg::*;

  typedef struct {
    logic        weA;
    logic [4:0]  addrA;
    logic [31:0] dataA;
    logic        weB;
    logic [4:0]  addrB;
    logic [31:0] dataB;
    logic        lsuRdy;
    logic        mduRdy;
    logic        stall;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  regfile_write_scheduler_if bus ();

  regfile_write_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.exceptionPending = 0;
    bus.coreWeA = 0; bus.coreWeB = 0;
    bus.coreAddrA = 0; bus.coreAddrB = 0; bus.coreDataA = 0; bus.coreDataB = 0;
    bus.issueLsu = 0; bus.issueLsuAddr = 0;
    bus.issueMdu = 0; bus.issueMduHiEn = 0; bus.issueMduLo = 0; bus.issueMduHi = 0;
    bus.lsuValid = 0; bus.lsuAddr = 0; bus.lsuData = 0;
    bus.mduValid = 0; bus.mduHiEn = 0; bus.mduAddrLo = 0; bus.mduAddrHi = 0;
    bus.mduDataLo = 0; bus.mduDataHi = 0;
    bus.readEnA = 0; bus.readEnB = 0; bus.readAddrA = 0; bus.readAddrB = 0;
    bus.destEn = 0; bus.destAddr = 0;
  endtask

  task automatic set_lsu(input logic [4:0] a, input logic [31:0] d);
    bus.lsuValid = 1; bus.lsuAddr = a; bus.lsuData = d;
  endtask

  task automatic set_mdu(input logic hi, input logic [4:0] lo_a, input logic [31:0] lo_d,
                         input logic [4:0] hi_a, input logic [31:0] hi_d);
    bus.mduValid = 1; bus.mduHiEn = hi;
    bus.mduAddrLo = lo_a; bus.mduDataLo = lo_d; bus.mduAddrHi = hi_a; bus.mduDataHi = hi_d;
  endtask

  task automatic compare_head();
    exp_t e;
    e = exp_q.pop_front();
    check_val("rfWeA", bus.rfWeA, e.weA);
    if (e.weA) begin
      check_val("rfAddrA", bus.rfAddrA, e.addrA);
      check_val("rfDataA", bus.rfDataA, e.dataA);
    end
    check_val("rfWeB", bus.rfWeB, e.weB);
    if (e.weB) begin
      check_val("rfAddrB", bus.rfAddrB, e.addrB);
      check_val("rfDataB", bus.rfDataB, e.dataB);
    end
    check_val("lsuReady", bus.lsuReady, e.lsuRdy);
    check_val("mduReady", bus.mduReady, e.mduRdy);
    check_val("stall", bus.stall, e.stall);
    if (bus.rfWeA && bus.rfWeB && (bus.rfAddrA == bus.rfAddrB))
      $display("WARNING protocol: both ports write r%0d in one cycle", bus.rfAddrA);
  endtask

  // Push the expectation for the cycle just driven, compare at negedge, advance to next cycle.
  task automatic expect_cycle(input logic weA, input logic [4:0] aA, input logic [31:0] dA,
                              input logic weB, input logic [4:0] aB, input logic [31:0] dB,
                              input logic lr, input logic mr, input logic st);
    exp_t e;
    e.weA = weA; e.addrA = aA; e.dataA = dA;
    e.weB = weB; e.addrB = aB; e.dataB = dB;
    e.lsuRdy = lr; e.mduRdy = mr; e.stall = st;
    exp_q.push_back(e);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    // Requests present during reset must not produce writes or readies.
    bus.coreWeA = 1; bus.coreAddrA = 5'd1; bus.coreDataA = 32'h11;
    set_lsu(5'd7, 32'h77);
    #2;
    check_val("rst_busy", bus.busyMask, 32'h0);
    check_val("rst_stall", bus.stall, 1'b0);
    check_val("rst_weA", bus.rfWeA, 1'b0);
    check_val("rst_lsuRdy", bus.lsuReady, 1'b0);
    #10;
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // Core on A, LSU falls to B; core B blocks LSU until it drops.
    bus.coreWeA = 1; bus.coreAddrA = 5'd3; bus.coreDataA = 32'h0300_0033;
    set_lsu(5'd7, 32'h77);
    expect_cycle(1, 5'd3, 32'h0300_0033, 1, 5'd7, 32'h77, 1, 0, 0);
    set_lsu(5'd8, 32'h88);
    bus.coreWeB = 1; bus.coreAddrB = 5'd10; bus.coreDataB = 32'hAA;
    for (int i = 0; i < 2; i++)
      expect_cycle(1, 5'd3, 32'h0300_0033, 1, 5'd10, 32'hAA, 0, 0, 0);
    bus.coreWeB = 0;
    expect_cycle(1, 5'd3, 32'h0300_0033, 1, 5'd8, 32'h88, 1, 0, 0);
    idle();

    // Free ports, LSU vs dual MDU: LSU first, then MDU Lo->A/Hi->B.
    set_lsu(5'd4, 32'h44);
    set_mdu(1, 5'd5, 32'h55, 5'd6, 32'h66);
    expect_cycle(1, 5'd4, 32'h44, 0, 5'd0, 32'h0, 1, 0, 0);
    bus.lsuValid = 0;
    expect_cycle(1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 0, 1, 0);
    // Pointer now favours MDU.
    set_lsu(5'd11, 32'hB1);
    set_mdu(1, 5'd14, 32'hE4, 5'd15, 32'hF5);
    expect_cycle(1, 5'd14, 32'hE4, 1, 5'd15, 32'hF5, 0, 1, 0);
    bus.mduValid = 0;
    expect_cycle(1, 5'd11, 32'hB1, 0, 5'd0, 32'h0, 1, 0, 0);
    // Both fit: LSU on A, single MDU on B; pointer unchanged.
    set_lsu(5'd12, 32'hC2);
    set_mdu(0, 5'd13, 32'hD3, 5'd0, 32'h0);
    expect_cycle(1, 5'd12, 32'hC2, 1, 5'd13, 32'hD3, 1, 1, 0);
    // One free port (core on A): LSU favoured, then MDU, then LSU again.
    bus.coreWeA = 1; bus.coreAddrA = 5'd1; bus.coreDataA = 32'h11;
    set_lsu(5'd16, 32'h160);
    set_mdu(0, 5'd17, 32'h170, 5'd0, 32'h0);
    expect_cycle(1, 5'd1, 32'h11, 1, 5'd16, 32'h160, 1, 0, 0);
    set_lsu(5'd18, 32'h180);
    expect_cycle(1, 5'd1, 32'h11, 1, 5'd17, 32'h170, 0, 1, 0);
    bus.mduValid = 0;
    expect_cycle(1, 5'd1, 32'h11, 1, 5'd18, 32'h180, 1, 0, 0);
    idle();

    // Scoreboard hazard on r9 and release one cycle after the granted write.
    bus.issueLsu = 1; bus.issueLsuAddr = 5'd9;
    expect_cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);
    bus.issueLsu = 0;
    bus.readEnA = 1; bus.readAddrA = 5'd9;
    expect_cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 1);
    check_val("busy_r9", bus.busyMask, 32'h0000_0200);
    bus.readEnA = 0; bus.readEnB = 1; bus.readAddrB = 5'd9;
    expect_cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 1);
    bus.readEnB = 0; bus.destEn = 1; bus.destAddr = 5'd9;
    expect_cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 1);
    bus.destEn = 0; bus.readEnA = 1; bus.readAddrA = 5'd10;
    expect_cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);
    bus.readEnA = 0; bus.readAddrA = 5'd9;
    expect_cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);
    bus.readEnA = 1;
    set_lsu(5'd9, 32'h99);
    expect_cycle(1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 1, 0, 1);
    bus.lsuValid = 0;
    expect_cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);
    check_val("busy_clear_r9", bus.busyMask, 32'h0);
    idle();

    // Same-edge clear (MDU grant) and set (issueLsu) on r5: set wins.
    bus.issueMdu = 1; bus.issueMduLo = 5'd5;
    expect_cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);
    bus.issueMdu = 0;
    set_mdu(0, 5'd5, 32'h505, 5'd0, 32'h0);
    bus.issueLsu = 1; bus.issueLsuAddr = 5'd5;
    expect_cycle(1, 5'd5, 32'h505, 0, 5'd0, 32'h0, 0, 1, 0);
    idle();
    check_val("busy_set_wins", bus.busyMask, 32'h0000_0020);
    set_lsu(5'd5, 32'h5A5);
    expect_cycle(1, 5'd5, 32'h5A5, 0, 5'd0, 32'h0, 1, 0, 0);
    check_val("busy_r5_cleared", bus.busyMask, 32'h0);
    idle();

    // Exception suppresses the core write; LSU takes port A.
    bus.exceptionPending = 1;
    bus.coreWeA = 1; bus.coreAddrA = 5'd2; bus.coreDataA = 32'h22;
    set_lsu(5'd8, 32'h80);
    expect_cycle(1, 5'd8, 32'h80, 0, 5'd0, 32'h0, 1, 0, 0);
    idle();

    // Build busy = 0x0F00, then assert reset mid-cycle.
    bus.issueLsu = 1; bus.issueLsuAddr = 5'd8;
    bus.issueMdu = 1; bus.issueMduHiEn = 1; bus.issueMduLo = 5'd9; bus.issueMduHi = 5'd10;
    expect_cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);
    idle();
    bus.issueLsu = 1; bus.issueLsuAddr = 5'd11;
    expect_cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);
    idle();
    check_val("busy_f00", bus.busyMask, 32'h0000_0F00);
    bus.coreWeA = 1; bus.coreAddrA = 5'd1; bus.coreDataA = 32'h11;
    bus.coreWeB = 1; bus.coreAddrB = 5'd2; bus.coreDataB = 32'h22;
    bus.readEnA = 1; bus.readAddrA = 5'd8;
    #1;
    check_val("pre_rst_stall", bus.stall, 1'b1);
    reset = 1'b0;
    #1;
    check_val("mid_rst_busy", bus.busyMask, 32'h0);
    check_val("mid_rst_stall", bus.stall, 1'b0);
    check_val("mid_rst_weA", bus.rfWeA, 1'b0);
    check_val("mid_rst_weB", bus.rfWeB, 1'b0);
    @(posedge clk);
    #1;
    check_val("held_rst_busy", bus.busyMask, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    bus.coreWeA = 1; bus.coreAddrA = 5'd1; bus.coreDataA = 32'h11;
    set_lsu(5'd20, 32'h200);
    expect_cycle(1, 5'd1, 32'h11, 1, 5'd20, 32'h200, 1, 0, 0);
    idle();

    check_val("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
